// File: rtl/sargantana_icache_pkg.sv
// Shared types for the sargantana icache tag array: flush-walk FSM states,
// default geometry and the per-way vector type.
package sargantana_icache_pkg;

  localparam int unsigned DEFAULT_NUM_WAYS  = 4;
  localparam int unsigned DEFAULT_TAG_DEPTH = 64;
  localparam int unsigned DEFAULT_TAG_WIDTH = 20;

  typedef enum logic {
    TAG_IDLE,
    TAG_FLUSH
  } tag_flush_state_e;

  typedef logic [DEFAULT_NUM_WAYS-1:0] tag_way_vec_t;

endpackage

// File: rtl/sargantana_tag_bank.sv
// One way of the icache tag array: tag RAM, valid array and registered read port.
// Optional per-entry even parity under SARGANTANA_ICACHE_TAG_PARITY_EN.
module sargantana_tag_bank
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned TAG_DEPTH      = DEFAULT_TAG_DEPTH,
  parameter int unsigned TAG_ADDR_WIDTH = $clog2(TAG_DEPTH),
  parameter int unsigned TAG_WIDTH      = DEFAULT_TAG_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      tag_we,
  input  logic                      valid_we,
  input  logic                      valid_wdata,
  input  logic                      re,
  input  logic [TAG_ADDR_WIDTH-1:0] addr,
  input  logic [TAG_WIDTH-1:0]      tag_wdata,
  output logic [TAG_WIDTH-1:0]      rd_tag,
  output logic                      rd_valid,
  output logic                      parity_err
);

  logic [TAG_WIDTH-1:0] tag_mem [TAG_DEPTH];
  logic [TAG_DEPTH-1:0] valid_mem;
  logic                 mismatch;

  always_ff @(posedge clk_i) begin
    if (tag_we) tag_mem[addr] <= tag_wdata;
    if (valid_we) valid_mem[addr] <= valid_wdata;
  end

`ifdef SARGANTANA_ICACHE_TAG_PARITY_EN
  logic [TAG_DEPTH-1:0] parity_mem;

  always_ff @(posedge clk_i) begin
    if (tag_we) parity_mem[addr] <= ^tag_wdata;
  end

  // Only valid entries are checked: never-written tags hold arbitrary parity.
  assign mismatch = valid_mem[addr] & ((^tag_mem[addr]) != parity_mem[addr]);
`else
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_tag     <= '0;
      rd_valid   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (re) begin
        rd_tag     <= tag_mem[addr];
        rd_valid   <= valid_mem[addr] & ~mismatch;
        parity_err <= mismatch;
      end
    end
  end

endmodule

// File: rtl/sargantana_tag_array_nway.sv
// N-way icache tag array: flush-walk FSM, registered compare tag and hit logic.
// Optional tag parity enabled by defining SARGANTANA_ICACHE_TAG_PARITY_EN.
module sargantana_tag_array_nway
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned NUM_WAYS       = DEFAULT_NUM_WAYS,
  parameter int unsigned TAG_DEPTH      = DEFAULT_TAG_DEPTH,
  parameter int unsigned TAG_ADDR_WIDTH = $clog2(TAG_DEPTH),
  parameter int unsigned TAG_WIDTH      = DEFAULT_TAG_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [NUM_WAYS-1:0]           way_sel_i,
  input  logic                          vbit_i,
  input  logic                          flush_i,
  input  logic [TAG_ADDR_WIDTH-1:0]     addr_i,
  input  logic [TAG_WIDTH-1:0]          data_i,
  input  logic [TAG_WIDTH-1:0]          cmp_tag_i,
  output logic [NUM_WAYS*TAG_WIDTH-1:0] tags_o,
  output logic [NUM_WAYS-1:0]           vbits_o,
  output logic [NUM_WAYS-1:0]           hit_way_o,
  output logic                          hit_o,
  output logic                          multi_hit_o,
  output logic                          busy_o,
  output logic                          parity_err_o
);

  tag_flush_state_e          state_q, state_d;
  logic [TAG_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]      cmp_tag_q;
  logic [TAG_ADDR_WIDTH-1:0] bank_addr;
  logic [NUM_WAYS-1:0]       bank_perr;
  logic                      rd_en, wr_en, walk_last;

  // Requests are only honoured in IDLE; a same-cycle flush takes priority.
  assign busy_o    = (state_q == TAG_FLUSH);
  assign rd_en     = req_i & ~we_i & ~busy_o & ~flush_i & ~rst_i;
  assign wr_en     = req_i &  we_i & ~busy_o & ~flush_i & ~rst_i;
  assign walk_last = (cnt_q == TAG_ADDR_WIDTH'(TAG_DEPTH - 1));
  assign bank_addr = busy_o ? cnt_q : addr_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      TAG_IDLE: begin
        if (flush_i) begin
          state_d = TAG_FLUSH;
          cnt_d   = '0;
        end
      end
      TAG_FLUSH: begin
        if (flush_i) cnt_d = '0;
        else if (walk_last) state_d = TAG_IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = TAG_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= TAG_FLUSH;
      cnt_q     <= '0;
      cmp_tag_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_en) cmp_tag_q <= cmp_tag_i;
    end
  end

  // The walk reuses each bank's single port to clear one set of valid bits per cycle.
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    sargantana_tag_bank #(
      .TAG_DEPTH      (TAG_DEPTH),
      .TAG_ADDR_WIDTH (TAG_ADDR_WIDTH),
      .TAG_WIDTH      (TAG_WIDTH)
    ) u_bank (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .tag_we      (wr_en & way_sel_i[w]),
      .valid_we    (busy_o | (wr_en & way_sel_i[w])),
      .valid_wdata (vbit_i & ~busy_o),
      .re          (rd_en),
      .addr        (bank_addr),
      .tag_wdata   (data_i),
      .rd_tag      (tags_o[w*TAG_WIDTH +: TAG_WIDTH]),
      .rd_valid    (vbits_o[w]),
      .parity_err  (bank_perr[w])
    );

    assign hit_way_o[w] = vbits_o[w] & (tags_o[w*TAG_WIDTH +: TAG_WIDTH] == cmp_tag_q);
  end

  assign hit_o        = |hit_way_o;
  assign multi_hit_o  = |(hit_way_o & (hit_way_o - 1'b1));
  assign parity_err_o = |bank_perr;

endmodule

// File: tb/tb_sargantana_tag_array_nway.sv
// Self-checking bench for sargantana_tag_array_nway: directed steps plus random
// traffic against an array-based reference model of the tag store.
`timescale 1ns/1ps
module tb_sargantana_tag_array_nway;
  import sargantana_icache_pkg::*;

  localparam int NW    = 4;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int TW    = 20;

  logic              clk_i = 1'b0;
  logic              rst_i, req_i, we_i, vbit_i, flush_i;
  logic [NW-1:0]     way_sel_i;
  logic [AW-1:0]     addr_i;
  logic [TW-1:0]     data_i, cmp_tag_i;
  logic [NW*TW-1:0]  tags_o;
  logic [NW-1:0]     vbits_o, hit_way_o;
  logic              hit_o, multi_hit_o, busy_o, parity_err_o;

  always #5 clk_i = ~clk_i;

  sargantana_tag_array_nway dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .way_sel_i    (way_sel_i),
    .vbit_i       (vbit_i),
    .flush_i      (flush_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .cmp_tag_i    (cmp_tag_i),
    .tags_o       (tags_o),
    .vbits_o      (vbits_o),
    .hit_way_o    (hit_way_o),
    .hit_o        (hit_o),
    .multi_hit_o  (multi_hit_o),
    .busy_o       (busy_o),
    .parity_err_o (parity_err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: storage contents plus the expected registered read result.
  logic [TW-1:0] m_tag   [NW][DEPTH];
  bit            m_known [NW][DEPTH];
  bit            m_valid [NW][DEPTH];
  bit            m_bad   [NW][DEPTH];
  int            m_walk = 0;
  logic [TW-1:0] e_tags  [NW];
  bit            e_known [NW];
  tag_way_vec_t  e_vbits, e_hit;
  bit            e_perr;

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_valids();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < DEPTH; s++) m_valid[w][s] = 1'b0;
  endtask

  task automatic modelStep();
    e_perr = 1'b0;
    if (rst_i) begin
      m_walk = DEPTH;
      clear_valids();
      for (int w = 0; w < NW; w++) begin
        e_tags[w]  = '0;
        e_known[w] = 1'b1;
      end
      e_vbits = '0;
      e_hit   = '0;
    end else if (m_walk > 0) begin
      if (flush_i) m_walk = DEPTH;
      else m_walk--;
    end else if (flush_i) begin
      m_walk = DEPTH;
      clear_valids();
    end else if (req_i && we_i) begin
      for (int w = 0; w < NW; w++) begin
        if (way_sel_i[w]) begin
          m_tag[w][addr_i]   = data_i;
          m_known[w][addr_i] = 1'b1;
          m_valid[w][addr_i] = vbit_i;
          m_bad[w][addr_i]   = 1'b0;
        end
      end
    end else if (req_i) begin
      for (int w = 0; w < NW; w++) begin
        e_tags[w]  = m_tag[w][addr_i];
        e_known[w] = m_known[w][addr_i];
        e_vbits[w] = m_valid[w][addr_i] && !m_bad[w][addr_i];
        e_hit[w]   = e_vbits[w] && (m_tag[w][addr_i] == cmp_tag_i);
        if (m_valid[w][addr_i] && m_bad[w][addr_i]) e_perr = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    compare("busy", 32'(busy_o), 32'(m_walk > 0));
    compare("vbits", 32'(vbits_o), 32'(e_vbits));
    compare("hit_way", 32'(hit_way_o), 32'(e_hit));
    compare("hit", 32'(hit_o), 32'(|e_hit));
    compare("multi_hit", 32'(multi_hit_o), 32'($countones(e_hit) > 1));
    compare("parity_err", 32'(parity_err_o), 32'(e_perr));
    for (int w = 0; w < NW; w++)
      if (e_known[w]) compare($sformatf("tag_w%0d", w), 32'(tags_o[w*TW +: TW]), 32'(e_tags[w]));
  endtask

  task automatic applyStimulus(input bit rst, input bit req, input bit we, input logic [NW-1:0] sel,
                               input bit vbit, input bit flush, input logic [AW-1:0] addr,
                               input logic [TW-1:0] data, input logic [TW-1:0] cmp);
    rst_i = rst; req_i = req; we_i = we; way_sel_i = sel; vbit_i = vbit;
    flush_i = flush; addr_i = addr; data_i = data; cmp_tag_i = cmp;
    @(posedge clk_i);
    modelStep();
    #1;
    checkOutput();
    rst_i = 1'b0; req_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 6'd0, 20'h0, 20'h0);
  endtask

  // Counts busy cycles (including the current one) until the walk ends, bounded.
  task automatic measure_walk(input string tag, input bit poke_reads);
    int n;
    n = busy_o ? 1 : 0;
    for (int i = 0; i < 200 && busy_o; i++) begin
      applyStimulus(1'b0, poke_reads, 1'b0, 4'b0000, 1'b0, 1'b0, 6'($urandom_range(0, 63)), 20'h0, 20'hABCDE);
      if (busy_o) n++;
    end
    compare(tag, 32'(n), 32'd64);
  endtask

  logic [TW-1:0] pool [4];

  initial begin
    pool[0] = 20'hABCDE; pool[1] = 20'h12345; pool[2] = 20'h00077; pool[3] = 20'h0;

    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 6'd0, 20'h0, 20'h0);
    compare("reset_busy", 32'(busy_o), 32'd1);
    compare("reset_hit", 32'(hit_o), 32'd0);
    measure_walk("reset_walk_len", 1'b1);

    // Single-way hit and tag readback.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 6'd5, 20'hABCDE, 20'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 6'd5, 20'h0, 20'hABCDE);
    compare("dir_hit_way", 32'(hit_way_o), 32'b0100);
    compare("dir_hit", 32'(hit_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 6'd5, 20'h0, 20'h12345);
    compare("dir_miss", 32'(hit_o), 32'd0);
    compare("dir_tag_w2", 32'(tags_o[2*TW +: TW]), 32'h000ABCDE);
    compare("dir_vbits", 32'(vbits_o), 32'b0100);
    idle();
    compare("dir_hold_vbits", 32'(vbits_o), 32'b0100);

    // Two-way write gives a multi-hit.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b1001, 1'b1, 1'b0, 6'd9, 20'h00077, 20'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 6'd9, 20'h0, 20'h00077);
    compare("dir_multi_way", 32'(hit_way_o), 32'b1001);
    compare("dir_multi", 32'(multi_hit_o), 32'd1);

    // way_sel of zero must not disturb the stored entry.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 6'd12, 20'h11111, 20'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 6'd12, 20'h22222, 20'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 6'd12, 20'h0, 20'h11111);
    compare("dir_nosel_hit", 32'(hit_way_o), 32'b0010);

    // Flush restarted mid-walk; flush wins over a same-cycle write.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 6'd12, 20'h33333, 20'h0);
    for (int i = 0; i < 30; i++) idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 6'd0, 20'h0, 20'h0);
    measure_walk("flush_walk_len", 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 6'd5, 20'h0, 20'hABCDE);
    compare("flush_vbits", 32'(vbits_o), 32'd0);
    compare("flush_hit", 32'(hit_o), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 6'd12, 20'h0, 20'h0);
    compare("flush_prio_tag_w1", 32'(tags_o[1*TW +: TW]), 32'h00011111);

`ifdef SARGANTANA_ICACHE_TAG_PARITY_EN
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 6'd3, 20'h0F0F0, 20'h0);
    dut.g_way[1].u_bank.tag_mem[3][0] = ~dut.g_way[1].u_bank.tag_mem[3][0];
    m_tag[1][3][0] = ~m_tag[1][3][0];
    m_bad[1][3] = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 6'd3, 20'h0, 20'h0F0F1);
    compare("par_err", 32'(parity_err_o), 32'd1);
    idle();
    compare("par_err_pulse", 32'(parity_err_o), 32'd0);
`endif

    // Random traffic over a few sets so hits, misses and overwrites all occur.
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 399));
      pool[3] = 20'($urandom());
      applyStimulus(r == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, r >= 1 && r <= 2,
                    6'($urandom_range(0, 7)), pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
